// File: rtl/puf_meas_sequencer_if.sv
// Control/status bundle between the PUF measurement sequencer and its host.
// The sequencer takes the slave view; the host/bench takes the master view.
interface puf_meas_sequencer_if #(
   parameter int MODE_BITS = 3,
   parameter int CNT_BITS  = 20,
   parameter int CH_BITS   = 2,
   parameter int RND_BITS  = 8
);
   logic                 I_en;
   logic [MODE_BITS-1:0] I_mode;
   logic                 I_start;
   logic [CH_BITS-1:0]   I_ch;
   logic [CNT_BITS-1:0]  I_half_period;
   logic [RND_BITS-1:0]  I_rounds;
   logic                 O_meas_rst;
   logic [CH_BITS-1:0]   O_ch_sel;
   logic                 O_sample;
   logic                 O_busy;
   logic                 O_ready;
   logic                 O_done;
   logic                 O_err;

   modport master (
      output I_en, I_mode, I_start, I_ch, I_half_period, I_rounds,
      input  O_meas_rst, O_ch_sel, O_sample, O_busy, O_ready, O_done, O_err
   );

   modport slave (
      input  I_en, I_mode, I_start, I_ch, I_half_period, I_rounds,
      output O_meas_rst, O_ch_sel, O_sample, O_busy, O_ready, O_done, O_err
   );
endinterface

// File: rtl/puf_meas_sequencer.sv
// Sequences reset/measure phases over PUF channels, plus the legacy free-running
// toggle mode. Every output is a flop loaded from the next-state values.
module puf_meas_sequencer #(
   parameter int MODE_BITS = 3,
   parameter int CNT_BITS  = 20,
   parameter int NUM_CH    = 4,
   parameter int CH_BITS   = 2,
   parameter int RND_BITS  = 8
) (
   input logic I_clk,
   input logic I_rst,
   puf_meas_sequencer_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_LEGACY, S_RST, S_MEAS, S_DONE} state_t;

   localparam logic [CH_BITS-1:0] CH_LAST = CH_BITS'(NUM_CH - 1);

   state_t              state_q, state_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d, p_q, p_d;
   logic [RND_BITS-1:0] rnd_q, rnd_d, r_q, r_d;
   logic [CH_BITS-1:0]  ch_q, ch_d, ch_req;
   logic                sweep_q, sweep_d;
   logic                meas_rst_q, meas_rst_d, sample_q, sample_d;
   logic                busy_q, busy_d, ready_q, ready_d;
   logic                done_q, done_d, err_q, err_d;
   logic [CH_BITS-1:0]  ch_sel_q, ch_sel_d;
   logic                mode_leg, mode_one, mode_swp;

   assign mode_leg = (bus.I_mode == '0);
   assign mode_one = (bus.I_mode == MODE_BITS'(1));
   assign mode_swp = (bus.I_mode == MODE_BITS'(2));
   assign ch_req   = (bus.I_ch > CH_LAST) ? CH_LAST : bus.I_ch;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rnd_d   = rnd_q;
      ch_d    = ch_q;
      p_d     = p_q;
      r_d     = r_q;
      sweep_d = sweep_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.I_en) begin
               if (mode_leg) begin
                  state_d = S_LEGACY;
                  cnt_d   = '0;
               end else if (bus.I_start) begin
                  if (mode_one || mode_swp) begin
                     state_d = S_RST;
                     cnt_d   = '0;
                     rnd_d   = '0;
                     p_d     = bus.I_half_period;
                     r_d     = bus.I_rounds;
                     sweep_d = mode_swp;
                     ch_d    = mode_swp ? '0 : ch_req;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
         end
         S_LEGACY: begin
            if (!mode_leg) state_d = S_IDLE;
            else           cnt_d   = cnt_q + 1'b1;
         end
         S_RST: begin
            if (cnt_q == p_q) begin
               state_d = S_MEAS;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_MEAS: begin
            if (cnt_q == p_q) begin
               cnt_d = '0;
               if (rnd_q != r_q) begin
                  rnd_d   = rnd_q + 1'b1;
                  state_d = S_RST;
               end else if (sweep_q && ch_q != CH_LAST) begin
                  ch_d    = ch_q + 1'b1;
                  rnd_d   = '0;
                  state_d = S_RST;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Enable drop aborts from any active state without done/sample side effects.
      if (!bus.I_en && state_q != S_IDLE) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end

      meas_rst_d = 1'b0;
      if (state_d == S_RST)
         meas_rst_d = 1'b1;
      else if (state_d == S_LEGACY && state_q == S_LEGACY)
         meas_rst_d = meas_rst_q ^ (&cnt_q);
      sample_d = (state_d == S_MEAS) && (cnt_d == p_d);
      busy_d   = (state_d != S_IDLE);
      ready_d  = (state_d == S_IDLE) && bus.I_en;
      done_d   = (state_d == S_DONE);
      ch_sel_d = (state_d == S_RST || state_d == S_MEAS || state_d == S_DONE) ? ch_d : '0;
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         rnd_q      <= '0;
         ch_q       <= '0;
         p_q        <= '0;
         r_q        <= '0;
         sweep_q    <= 1'b0;
         meas_rst_q <= 1'b0;
         sample_q   <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         ch_sel_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rnd_q      <= rnd_d;
         ch_q       <= ch_d;
         p_q        <= p_d;
         r_q        <= r_d;
         sweep_q    <= sweep_d;
         meas_rst_q <= meas_rst_d;
         sample_q   <= sample_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
         err_q      <= err_d;
         ch_sel_q   <= ch_sel_d;
      end
   end

   assign bus.O_meas_rst = meas_rst_q;
   assign bus.O_ch_sel   = ch_sel_q;
   assign bus.O_sample   = sample_q;
   assign bus.O_busy     = busy_q;
   assign bus.O_ready    = ready_q;
   assign bus.O_done     = done_q;
   assign bus.O_err      = err_q;
endmodule

// File: tb/tb_puf_meas_sequencer.sv
// Bench for puf_meas_sequencer: table of run summaries, exact per-cycle trace
// model for sequences, plus legacy, abort, invalid-mode and reset sequences.
module tb_puf_meas_sequencer;
   localparam int MB = 3, CB = 4, NC = 4, CHB = 3, RB = 3;

   logic I_clk = 1'b0;
   logic I_rst;
   always #5 I_clk = ~I_clk;

   puf_meas_sequencer_if #(.MODE_BITS(MB), .CNT_BITS(CB), .CH_BITS(CHB), .RND_BITS(RB)) bus ();

   puf_meas_sequencer #(.MODE_BITS(MB), .CNT_BITS(CB), .NUM_CH(NC), .CH_BITS(CHB), .RND_BITS(RB))
      dut (.I_clk(I_clk), .I_rst(I_rst), .bus(bus));

   typedef struct {
      int mode; int ch; int p; int r;
      int len; int nsmp; int fch; int lch;
   } vec_t;

   int n_cmp = 0;
   int n_fail = 0;
   vec_t tbl[6];
   logic [8:0] exp_q[$];
   logic [8:0] msk_q[$];

   // obs bits: rst, ch[2:0], sample, busy, done, ready, err
   function automatic logic [8:0] obs();
      return {bus.O_meas_rst, bus.O_ch_sel, bus.O_sample, bus.O_busy,
              bus.O_done, bus.O_ready, bus.O_err};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge I_clk);
      #1;
   endtask

   function automatic logic [8:0] rec(int rst, int ch, int smp, int busy, int done);
      logic [8:0] v;
      v = {rst[0], ch[2:0], smp[0], busy[0], done[0], ~busy[0], 1'b0};
      return v;
   endfunction

   // Expected output trace of one accepted run, from the cycle after acceptance
   // through the first idle cycle afterwards.
   task automatic build(input int mode, input int ch, input int p, input int r);
      int c0, c1;
      exp_q.delete();
      msk_q.delete();
      c0 = (mode == 2) ? 0 : ((ch > NC - 1) ? NC - 1 : ch);
      c1 = (mode == 2) ? NC - 1 : c0;
      for (int c = c0; c <= c1; c++)
         for (int k = 0; k <= r; k++) begin
            for (int i = 0; i <= p; i++) begin
               exp_q.push_back(rec(1, c, 0, 1, 0)); msk_q.push_back(9'h1ff);
            end
            for (int i = 0; i <= p; i++) begin
               exp_q.push_back(rec(0, c, (i == p) ? 1 : 0, 1, 0)); msk_q.push_back(9'h1ff);
            end
         end
      exp_q.push_back(rec(0, 0, 0, 1, 1)); msk_q.push_back(9'h11f);
      exp_q.push_back(rec(0, 0, 0, 0, 0)); msk_q.push_back(9'h11f);
   endtask

   task automatic run_trace(input string name, input int mode, input int ch,
                            input int p, input int r, input bit junk);
      bus.I_mode = MB'(mode);
      bus.I_ch = CHB'(ch);
      bus.I_half_period = CB'(p);
      bus.I_rounds = RB'(r);
      bus.I_start = 1'b1;
      tick();
      bus.I_start = 1'b0;
      build(mode, ch, p, r);
      for (int i = 0; i < exp_q.size(); i++) begin
         chk(name, int'(obs() & msk_q[i]), int'(exp_q[i]));
         if (junk && i < exp_q.size() - 1) begin
            bus.I_half_period = CB'($urandom);
            bus.I_rounds = RB'($urandom);
            bus.I_ch = CHB'($urandom);
            bus.I_start = 1'($urandom);
         end else begin
            bus.I_start = 1'b0;
         end
         tick();
      end
      bus.I_start = 1'b0;
   endtask

   task automatic run_stats(input int idx, input vec_t v);
      int len, n, f, l;
      bit seen;
      len = 0; n = 0; f = -1; l = -1; seen = 0;
      bus.I_mode = MB'(v.mode);
      bus.I_ch = CHB'(v.ch);
      bus.I_half_period = CB'(v.p);
      bus.I_rounds = RB'(v.r);
      bus.I_start = 1'b1;
      tick();
      bus.I_start = 1'b0;
      for (int i = 0; i < 1000 && !seen; i++) begin
         if (bus.O_busy) len++;
         if (bus.O_sample) begin
            if (n == 0) f = int'(bus.O_ch_sel);
            l = int'(bus.O_ch_sel);
            n++;
         end
         if (bus.O_done) seen = 1;
         tick();
      end
      chk($sformatf("tbl%0d_done_seen", idx), int'(seen), 1);
      chk($sformatf("tbl%0d_len", idx), len, v.len);
      chk($sformatf("tbl%0d_nsmp", idx), n, v.nsmp);
      chk($sformatf("tbl%0d_first_ch", idx), f, v.fch);
      chk($sformatf("tbl%0d_last_ch", idx), l, v.lch);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      tbl[0] = '{1, 2, 2, 1, 13, 2, 2, 2};
      tbl[1] = '{2, 0, 0, 0, 9, 4, 0, 3};
      tbl[2] = '{1, 7, 1, 0, 5, 1, 3, 3};
      tbl[3] = '{1, 0, 15, 0, 33, 1, 0, 0};
      tbl[4] = '{2, 5, 1, 7, 129, 32, 0, 3};
      tbl[5] = '{1, 1, 0, 7, 17, 8, 1, 1};

      I_rst = 1'b1;
      bus.I_en = 1'b1;
      bus.I_mode = MB'(1);
      bus.I_start = 1'b0;
      bus.I_ch = '0;
      bus.I_half_period = '0;
      bus.I_rounds = '0;
      repeat (3) begin
         tick();
         chk("reset_outputs", int'(obs()), 0);
      end
      I_rst = 1'b0;
      tick();
      chk("post_reset_ready", int'(obs()), 9'b0_000_0_0_0_1_0);

      run_trace("single_ch2", 1, 2, 2, 1, 0);
      run_trace("sweep_p0", 2, 0, 0, 0, 0);

      for (int i = 0; i < 6; i++) run_stats(i, tbl[i]);

      for (int k = 0; k < 8; k++)
         run_trace($sformatf("rand%0d", k), 1 + int'($urandom_range(1)),
                   int'($urandom_range(7)), int'($urandom_range(4)),
                   int'($urandom_range(3)), 1);

      // invalid mode rejected with a single err pulse
      bus.I_mode = MB'(5);
      bus.I_start = 1'b1;
      tick();
      bus.I_start = 1'b0;
      chk("err_pulse", int'(obs()), 9'b0_000_0_0_0_1_1);
      tick();
      chk("err_clear", int'(obs()), 9'b0_000_0_0_0_1_0);

      // abort during measurement of round 0
      bus.I_mode = MB'(1);
      bus.I_ch = CHB'(1);
      bus.I_half_period = CB'(5);
      bus.I_rounds = '0;
      bus.I_start = 1'b1;
      tick();
      bus.I_start = 1'b0;
      repeat (8) tick();
      chk("abort_in_meas", int'(obs()), 9'b0_001_0_1_0_0_0);
      bus.I_en = 1'b0;
      tick();
      chk("abort_idle", int'(obs()), 0);
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         if (i == 10) bus.I_en = 1'b1;
         if (bus.O_sample || bus.O_done) cnt++;
         tick();
      end
      chk("abort_no_sample_done", cnt, 0);
      chk("abort_ready_again", int'(obs()), 9'b0_000_0_0_0_1_0);

      // legacy free-run: LEGACY from cycle 1, toggle every 2^CB cycles
      bus.I_en = 1'b0;
      tick();
      bus.I_mode = '0;
      bus.I_en = 1'b1;
      tick();
      for (int t = 1; t <= 60; t++) begin
         chk($sformatf("legacy_c%0d", t), int'(obs()),
             int'({1'(((t - 1) >> CB) & 1), 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
         tick();
      end
      bus.I_mode = MB'(1);
      tick();
      chk("legacy_exit", int'(obs()), 9'b0_000_0_0_0_1_0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/puf_meas_sequencer.md
Name: puf_meas_sequencer

Overview:
Parametrised successor to the on-chip measurement-reset controller. It sequences PUF measurement cycles across NUM_CH channels. Each cycle has a reset phase (O_meas_rst high) followed by a measurement phase (O_meas_rst low), with a programmable phase length and round count. It also retains the legacy free-running toggle mode and provides busy, ready, sample-strobe and done handshakes to the downstream BCH/memory control.

Parameters:
MODE_BITS, 3, width of I_mode
CNT_BITS, 20, width of the phase counter and I_half_period
NUM_CH, 4, number of measurement channels (at least 1)
CH_BITS, 2, width of channel select (at least clog2(NUM_CH), minimum 1)
RND_BITS, 8, width of I_rounds

Ports:
I_clk  in  1  clock; all logic on the rising edge
I_rst  in  1  synchronous active-high reset
I_en  in  1  global enable; low aborts any activity
I_mode  in  MODE_BITS  0=legacy free-run, 1=single channel, 2=sweep; other values invalid
I_start  in  1  start request; sampled only in IDLE
I_ch  in  CH_BITS  channel for mode 1
I_half_period  in  CNT_BITS  P; each phase lasts P+1 cycles
I_rounds  in  RND_BITS  R; R+1 rounds per channel
O_meas_rst  out  1  measurement reset to the meas block
O_ch_sel  out  CH_BITS  active channel
O_sample  out  1  one-cycle strobe on the last cycle of each measurement phase
O_busy  out  1  sequence or legacy mode active
O_ready  out  1  high only in IDLE with I_en=1
O_done  out  1  one-cycle pulse on sequence completion
O_err  out  1  one-cycle pulse when a start with an invalid mode is rejected

Behaviour:
- All outputs are registered.
- Reset values: every output 0, state IDLE, all counters 0.
- I_rst has priority over everything.
- States: IDLE, LEGACY, RST, MEAS, DONE.
- IDLE → LEGACY: when I_en=1 and I_mode=0. No start is needed.
- IDLE → RST: when I_en=1, I_start=1 and I_mode is 1 or 2.
  - On acceptance, latch P, R and the mode.
  - Channel is I_ch in mode 1, 0 in mode 2.
- Invalid start: I_en=1, I_start=1 and I_mode ≥ 3. Pulse O_err for one cycle and stay in IDLE.
- If I_mode=0 and I_start=1 together, LEGACY wins and there is no O_err.
- Latched values are stable for the whole run; input changes mid-run are ignored.
- Start accepted at cycle N: O_busy=1, O_ready=0 and O_meas_rst=1 from cycle N+1.
- RST: O_meas_rst=1 for P+1 cycles, then MEAS.
- MEAS: O_meas_rst=0 for P+1 cycles. O_sample=1 on the last MEAS cycle.
- After MEAS, if rounds remain on this channel → RST (no gap cycle).
- After MEAS, if rounds are exhausted:
  - Mode 2 with channel < NUM_CH-1: channel+1, round count cleared, → RST.
  - Otherwise → DONE.
- O_ch_sel changes in the same cycle the new RST phase begins.
- DONE lasts one cycle: O_done=1, O_busy=1, O_meas_rst=0. Then IDLE with O_busy=0 and O_ready=1.
- LEGACY (bit-compatible with the previous generation):
  - Free-running CNT_BITS counter is cleared on entry and increments every cycle.
  - O_meas_rst toggles on each cycle the counter is all-ones, so a 2^CNT_BITS-cycle half-period.
  - O_ch_sel=0, O_busy=1, O_sample=0.
  - Exit to IDLE when I_en=0 or I_mode≠0; O_meas_rst is cleared on exit.
- Abort: I_en=0 in any non-IDLE state → IDLE next cycle.
  - O_meas_rst=0, O_busy=0.
  - No O_done and no O_sample.
- Boundary cases:
  - P=0 gives 1-cycle phases.
  - P = all-ones gives 2^CNT_BITS-cycle phases; the counter wraps only on phase exit.
  - R = all-ones gives 2^RND_BITS rounds.
  - I_ch ≥ NUM_CH in mode 1 is clamped to NUM_CH-1.
- Counter widths: the phase counter is CNT_BITS wide and compared for equality to P. The round counter is RND_BITS wide.

Test Plan:
1. Reset and idle: assert I_rst for 3 cycles with I_en=1 → all outputs 0 during reset. O_ready=1 from the first cycle after reset release; O_busy=0.
2. Single channel: I_mode=1, I_ch=2, P=2, R=1, start at cycle 0.
   - O_meas_rst=1 in cycles 1-3 and 7-9, 0 in cycles 4-6 and 10-12.
   - O_sample at cycles 6 and 12; O_ch_sel=2 throughout.
   - O_done at cycle 13; O_busy=0 and O_ready=1 at cycle 14.
3. Sweep: NUM_CH=4, P=0, R=0, I_mode=2, start at cycle 0.
   - O_ch_sel is 0, 1, 2, 3 for cycle pairs 1-2, 3-4, 5-6, 7-8.
   - O_meas_rst high on odd cycles; O_sample at cycles 2, 4, 6, 8.
   - O_done at cycle 9; exactly 4 samples.
4. Legacy: CNT_BITS=4, I_mode=0, I_en rises at cycle 0 → LEGACY from cycle 1. O_meas_rst rises at cycle 17, falls at cycle 33, rises at cycle 49.
5. Abort: P=5, run mode 1, drop I_en during MEAS of round 0 → next cycle IDLE with O_meas_rst=0 and O_busy=0. No O_sample and no O_done ever.
6. Invalid and clamp cases:
   - I_mode=5 with I_start → O_err pulse for 1 cycle and state stays IDLE.
   - Then mode 1 with I_ch=7 and NUM_CH=4 → O_ch_sel=3.
   - Changing I_half_period mid-run leaves phase lengths unchanged.
